// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART core stream output and the
// register block RX data port. First-word fall-through, never backpressures, sticky
// overflow, fill-level threshold interrupt.
// Optional idle-timeout interrupt is built only when UART_RX_FIFO_TIMEOUT_EN is defined;
// otherwise irq_timeout is tied low and timeout_cycles is ignored.

module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TIMEOUT_W  = 16,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    input  logic                  flush,
    input  logic [LW-1:0]         threshold,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles,
    input  logic                  ovf_clr,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  overflow,
    output logic                  irq_thresh,
    output logic                  irq_timeout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;

    logic                  push_c;
    logic                  pop_c;
    logic                  do_push_c;
    logic                  do_pop_c;
    logic                  ovf_set_c;
    logic [AW-1:0]         wr_ptr_nxt_c;
    logic [AW-1:0]         rd_ptr_nxt_c;
    logic [LW-1:0]         level_nxt_c;
    logic [DATA_WIDTH-1:0] rd_data_nxt_c;

    // Handshake decode: a full FIFO still accepts a byte when the head is popped the same cycle.
    always_comb begin
        push_c    = s_axis_tvalid & s_axis_tready;
        pop_c     = rd_ack & rd_valid;
        do_pop_c  = pop_c & ~flush;
        do_push_c = push_c & ~flush & (~full | pop_c);
        ovf_set_c = push_c & ~flush & full & ~pop_c;
    end

    // Next pointers, level and fall-through head value (bypass when the new head is being written).
    always_comb begin
        wr_ptr_nxt_c  = wr_ptr_q;
        rd_ptr_nxt_c  = rd_ptr_q;
        level_nxt_c   = level;
        rd_data_nxt_c = rd_data;
        if (flush) begin
            wr_ptr_nxt_c = '0;
            rd_ptr_nxt_c = '0;
            level_nxt_c  = '0;
        end else begin
            if (do_push_c) wr_ptr_nxt_c = wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_nxt_c = rd_ptr_q + AW'(1);
            if (do_push_c && !do_pop_c)      level_nxt_c = level + LW'(1);
            else if (!do_push_c && do_pop_c) level_nxt_c = level - LW'(1);
        end
        if (level_nxt_c != '0) begin
            if (do_push_c && (wr_ptr_q == rd_ptr_nxt_c)) rd_data_nxt_c = s_axis_tdata;
            else                                         rd_data_nxt_c = mem[rd_ptr_nxt_c];
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr_q] <= s_axis_tdata;
    end

    // Registered state and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level         <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            full          <= 1'b0;
            overflow      <= 1'b0;
            irq_thresh    <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_nxt_c;
            rd_ptr_q      <= rd_ptr_nxt_c;
            level         <= level_nxt_c;
            rd_valid      <= (level_nxt_c != '0);
            rd_data       <= rd_data_nxt_c;
            full          <= (level_nxt_c == LW'(DEPTH));
            irq_thresh    <= (threshold != '0) && (level_nxt_c >= threshold);
            s_axis_tready <= 1'b1;
            if (ovf_set_c)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_cnt_q;
    logic                 activity_c;

    always_comb activity_c = push_c | pop_c | flush;

    // Idle counter: runs only while data sits unread; saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (activity_c || (level == '0)) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != '1) begin
            idle_cnt_q <= idle_cnt_q + TIMEOUT_W'(1);
        end
    end

    // Timeout interrupt: set on reaching the programmed count, held until the next activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_timeout <= 1'b0;
        end else if (activity_c) begin
            irq_timeout <= 1'b0;
        end else if ((timeout_cycles != '0) && (idle_cnt_q == timeout_cycles)) begin
            irq_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles;
    assign irq_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH 16, 8-bit data).

module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ack;
    logic       flush;
    logic [4:0] threshold;
    logic [15:0] timeout_cycles;
    logic       ovf_clr;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic       irq_thresh;
    logic       irq_timeout;

    int total = 0;
    int bad   = 0;
    logic exp_to;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .TIMEOUT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ack         (rd_ack),
        .flush          (flush),
        .threshold      (threshold),
        .timeout_cycles (timeout_cycles),
        .ovf_clr        (ovf_clr),
        .level          (level),
        .full           (full),
        .overflow       (overflow),
        .irq_thresh     (irq_thresh),
        .irq_timeout    (irq_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] b);
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(b));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    initial begin
`ifdef UART_RX_FIFO_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; rd_ack = 1'b0;
        flush = 1'b0; threshold = '0; timeout_cycles = '0; ovf_clr = 1'b0;
        repeat (3) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_irq_thresh", 32'(irq_thresh), 32'd0);
        check("rst_irq_timeout", 32'(irq_timeout), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();
        check("tready_up", 32'(s_axis_tready), 32'd1);

        // Reset in the middle of traffic
        push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
        check("mid_level3", 32'(level), 32'd3);
        rst_n = 1'b0;
        #2;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill and drain in order
        push_byte(8'h00);
        check("first_level", 32'(level), 32'd1);
        check("first_valid", 32'(rd_valid), 32'd1);
        check("first_data", 32'(rd_data), 32'h00);
        for (int i = 1; i < 16; i++) push_byte(8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) pop_expect("drain", 8'(i));
        check("drain_level", 32'(level), 32'd0);
        check("drain_valid", 32'(rd_valid), 32'd0);
        check("drain_full", 32'(full), 32'd0);

        // Overflow and its clear priority
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        push_byte(8'hAA);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        ovf_clr = 1'b1;
        push_byte(8'hBB);
        check("ovf_set_beats_clr", 32'(overflow), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Push and pop on a full FIFO: no overflow, byte lands at the tail
        s_axis_tdata = 8'h55; s_axis_tvalid = 1'b1; rd_ack = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; rd_ack = 1'b0;
        check("fpp_level", 32'(level), 32'd16);
        check("fpp_ovf", 32'(overflow), 32'd0);
        check("fpp_full", 32'(full), 32'd1);
        for (int i = 1; i < 16; i++) pop_expect("fpp_order", 8'(8'h10 + i));
        pop_expect("fpp_last", 8'h55);
        check("fpp_empty", 32'(rd_valid), 32'd0);

        // rd_ack on empty is ignored; push+pop on empty keeps the push only
        rd_ack = 1'b1;
        tick();
        check("empty_ack_level", 32'(level), 32'd0);
        s_axis_tdata = 8'h77; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; rd_ack = 1'b0;
        check("empty_pp_level", 32'(level), 32'd1);
        check("empty_pp_data", 32'(rd_data), 32'h77);
        pop_expect("empty_pp_pop", 8'h77);

        // Threshold interrupt
        threshold = 5'd4;
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        check("thr_below", 32'(irq_thresh), 32'd0);
        push_byte(8'h04);
        check("thr_reach", 32'(irq_thresh), 32'd1);
        pop_expect("thr_pop", 8'h01);
        check("thr_drop", 32'(irq_thresh), 32'd0);
        threshold = 5'd0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
        check("thr_disabled", 32'(irq_thresh), 32'd0);
        check("thr_level8", 32'(level), 32'd8);

        // Flush with a same-cycle push and pop
        flush = 1'b1; s_axis_tdata = 8'hEE; s_axis_tvalid = 1'b1; rd_ack = 1'b1;
        tick();
        flush = 1'b0; s_axis_tvalid = 1'b0; rd_ack = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", 32'(rd_valid), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd0);
        push_byte(8'h99);
        check("post_flush_data", 32'(rd_data), 32'h99);

        // Idle timeout: counter reaches 100 idle cycles after the last push
        timeout_cycles = 16'd100;
        repeat (50) tick();
        check("to_early", 32'(irq_timeout), 32'd0);
        repeat (60) tick();
        check("to_fire", 32'(irq_timeout), 32'(exp_to));
        pop_expect("to_pop", 8'h99);
        check("to_clear", 32'(irq_timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
